// File: rtl/light_pkg.sv
// light_pkg: light state encodings and default timing constants shared by the
// light controller blocks.
package light_pkg;
  typedef enum logic [5:0] {
    HG = 6'b001100,
    HY = 6'b010100,
    FG = 6'b100001,
    FY = 6'b100010
  } light_e;
  localparam int DEF_CW          = 8;
  localparam int DEF_SHORT_CYC   = 5;
  localparam int DEF_LONG_CYC    = 15;
  localparam int DEF_EMER_CYC    = 2;
  localparam int DEF_DEB_CYC     = 3;
  localparam int DEF_AMB_MAX_CYC = 200;
endpackage

// File: rtl/light_timer_sched_sync_debounce.sv
// sync_debounce: 2-flop synchroniser followed by a run-length debouncer; dout
// follows the synced input once it has held a new value for DEB_CYC samples.
module sync_debounce #(
  parameter int DEB_CYC = 3
) (
  input  logic Clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int RW = $clog2(DEB_CYC + 1);
  logic s1, s2;
  logic [RW-1:0] run;
  always_ff @(posedge Clk)
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      run  <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) run <= '0;
      else if (run == RW'(DEB_CYC - 1)) begin
        dout <= s2;
        run  <= '0;
      end else run <= run + RW'(1);
    end
endmodule

// File: rtl/light_timer_sched.sv
// light_timer_sched: interval timer, car-sensor debounce and ambulance latch feeding
// the light FSM. Define AMB_TIMEOUT_EN to let AMB clear itself after AMB_MAX_CYC cycles.
module light_timer_sched
  import light_pkg::*;
#(
  parameter int CW          = DEF_CW,
  parameter int SHORT_CYC   = DEF_SHORT_CYC,
  parameter int LONG_CYC    = DEF_LONG_CYC,
  parameter int EMER_CYC    = DEF_EMER_CYC,
  parameter int DEB_CYC     = DEF_DEB_CYC,
  parameter int AMB_MAX_CYC = DEF_AMB_MAX_CYC
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          ST,
  input  logic          car_raw,
  input  logic          amb_raw,
  input  logic          amb_clr,
  output logic          TS,
  output logic          TL,
  output logic          TSE,
  output logic          C,
  output logic          AMB,
  output logic [CW-1:0] cnt
);
  if (!(EMER_CYC >= 1 && EMER_CYC <= SHORT_CYC && SHORT_CYC < LONG_CYC &&
        LONG_CYC < 2**CW - 1 && DEB_CYC >= 1 && AMB_MAX_CYC >= 1)) begin : g_bad_params
    $error("light_timer_sched: illegal timing parameters");
  end
  localparam logic [CW-1:0] CMAX = '1;
  always_ff @(posedge Clk)
    if (reset || ST) cnt <= '0;
    else if (cnt != CMAX) cnt <= cnt + CW'(1);
  assign TS  = cnt >= CW'(SHORT_CYC);
  assign TL  = cnt >= CW'(LONG_CYC);
  assign TSE = cnt >= CW'(EMER_CYC);
  sync_debounce #(.DEB_CYC(DEB_CYC)) u_car (.Clk, .reset, .din(car_raw), .dout(C));
  logic amb_sync, amb_prev, amb_rise;
  sync_debounce #(.DEB_CYC(1)) u_amb (.Clk, .reset, .din(amb_raw), .dout(amb_sync));
  assign amb_rise = amb_sync & ~amb_prev;
  // a new request outranks a simultaneous clear
`ifdef AMB_TIMEOUT_EN
  logic [15:0] age;
  always_ff @(posedge Clk)
    if (reset) begin
      amb_prev <= 1'b0;
      AMB      <= 1'b0;
      age      <= '0;
    end else begin
      amb_prev <= amb_sync;
      if (amb_rise) begin
        AMB <= 1'b1;
        age <= '0;
      end else if (amb_clr || (AMB && age == 16'(AMB_MAX_CYC - 1))) AMB <= 1'b0;
      else if (AMB) age <= age + 16'd1;
    end
`else
  always_ff @(posedge Clk)
    if (reset) begin
      amb_prev <= 1'b0;
      AMB      <= 1'b0;
    end else begin
      amb_prev <= amb_sync;
      if (amb_rise) AMB <= 1'b1;
      else if (amb_clr) AMB <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_light_timer_sched.sv
// tb_light_timer_sched: directed and random stimulus against a cycle-level model of
// the timer, debounce and ambulance rules.
module tb_light_timer_sched;
  localparam int AMB_MAX = 20;
  logic Clk = 0, reset = 1, ST = 0, car_raw = 0, amb_raw = 0, amb_clr = 0;
  logic TS, TL, TSE, C, AMB;
  logic [7:0] cnt;
  int errors = 0, checks = 0;
  int n = 0, m_cnt = 0, amb_set_n = 0;
  bit m_c = 0, m_amb = 0;
  bit car_h[$] = '{0, 0, 0, 0, 0};
  bit amb_h[$] = '{0, 0, 0, 0, 0};

  light_timer_sched #(.AMB_MAX_CYC(AMB_MAX)) dut (
    .Clk(Clk), .reset(reset), .ST(ST), .car_raw(car_raw), .amb_raw(amb_raw),
    .amb_clr(amb_clr), .TS(TS), .TL(TL), .TSE(TSE), .C(C), .AMB(AMB), .cnt(cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: synced input at an edge is the raw value seen two edges earlier; C adopts a
  // value once three successive synced samples agree; AMB edge detect sees one more delay.
  task automatic tick();
    @(posedge Clk);
    n++;
    car_h.push_front(car_raw);
    amb_h.push_front(amb_raw);
    void'(car_h.pop_back());
    void'(amb_h.pop_back());
    if (reset) begin
      m_cnt = 0; m_c = 0; m_amb = 0;
      car_h = '{0, 0, 0, 0, 0};
      amb_h = '{0, 0, 0, 0, 0};
    end else begin
      m_cnt = ST ? 0 : (m_cnt < 255 ? m_cnt + 1 : 255);
      if (car_h[2] == car_h[3] && car_h[3] == car_h[4]) m_c = car_h[2];
      if (amb_h[3] && !amb_h[4]) begin
        m_amb = 1; amb_set_n = n;
      end else if (amb_clr) m_amb = 0;
`ifdef AMB_TIMEOUT_EN
      else if (m_amb && n - amb_set_n == AMB_MAX) m_amb = 0;
`endif
    end
    #1;
    chk("cnt", cnt, m_cnt);
    chk("TS", TS, m_cnt >= 5);
    chk("TL", TL, m_cnt >= 15);
    chk("TSE", TSE, m_cnt >= 2);
    chk("C", C, m_c);
    chk("AMB", AMB, m_amb);
  endtask

  task automatic ticks(int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    #1;
    reset = 1; ticks(2);
    chk("rst_cnt", cnt, 0);
    chk("rst_flags", {TS, TL, TSE, C, AMB}, 0);
    reset = 0;
    ST = 1; tick(); ST = 0;
    chk("st_cnt0", cnt, 0);
    tick(); chk("tse_early", TSE, 0);
    tick(); chk("tse_first", TSE, 1);
    ticks(2); chk("ts_early", TS, 0);
    tick(); chk("ts_first", TS, 1);
    ticks(9); chk("tl_early", TL, 0);
    tick(); chk("tl_first", TL, 1);
    ticks(260);
    chk("sat_cnt", cnt, 255);
    chk("sat_flags", {TS, TL, TSE}, 3'b111);
    ST = 1; tick(); ST = 0;
    ticks(7); chk("cnt7", cnt, 7);
    ST = 1; tick(); ST = 0;
    chk("restart_ts", {TS, TSE}, 0);
    ticks(4); chk("restart_ts_early", TS, 0);
    tick(); chk("restart_ts_high", TS, 1);
    car_raw = 1; ticks(2); car_raw = 0;
    ticks(8); chk("glitch_c", C, 0);
    car_raw = 1; ticks(4); chk("c_early", C, 0);
    tick(); chk("c_rise", C, 1);
    ticks(5); car_raw = 0;
    ticks(4); chk("c_fall_early", C, 1);
    tick(); chk("c_fall", C, 0);
    amb_raw = 1; ticks(3);
    amb_clr = 1; tick(); amb_clr = 0;
    chk("amb_set_wins", AMB, 1);
    ticks(3);
    amb_clr = 1; tick(); amb_clr = 0;
    chk("amb_clr", AMB, 0);
    ticks(10); chk("amb_held_no_reset", AMB, 0);
    amb_raw = 0; car_raw = 1; ticks(2);
    amb_raw = 1; ST = 1; tick(); ST = 0;
    ticks(9);
    chk("pre_rst", {cnt, AMB, C}, {8'd9, 2'b11});
    reset = 1; amb_raw = 0; car_raw = 0; tick();
    chk("mid_rst", {cnt, TS, TL, TSE, AMB, C}, 0);
    reset = 0;
    ticks(6);
    amb_raw = 1; ticks(4);
    chk("amb_on", AMB, 1);
`ifdef AMB_TIMEOUT_EN
    ticks(19); chk("amb_before_timeout", AMB, 1);
    tick(); chk("amb_timeout", AMB, 0);
`else
    ticks(100); chk("amb_held", AMB, 1);
`endif
    for (int i = 0; i < 600; i++) begin
      ST = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0) car_raw = ~car_raw;
      if ($urandom_range(7) == 0) amb_raw = ~amb_raw;
      amb_clr = ($urandom_range(9) == 0);
      reset = ($urandom_range(99) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
